// File: rtl/disp_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scanner.
// Holds segment patterns, FSM state encoding, digit count and the data payload type.
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned DATA_W     = NUM_DIGITS * DIGIT_W;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned SEG_W      = 7;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F = 7'h71;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    // Displayed data: four nibbles (index 0 = digit 0) plus per-digit blank mask.
    typedef struct packed {
        logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits;
        logic [NUM_DIGITS-1:0]              blank;
    } disp_data_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bus between a display data source and display_scan_ctrl.
// master: drives load/digits_in/blank_in, observes scan outputs.
// slave : the scanner itself.
interface display_scan_ctrl_if;
    import disp_pkg::*;

    logic                  load;
    logic [DATA_W-1:0]     digits_in;
    logic [NUM_DIGITS-1:0] blank_in;
    logic [SEL_W-1:0]      dig_sel;
    logic [NUM_DIGITS-1:0] dig_en;
    logic [SEG_W-1:0]      seg;
    logic                  frame_done;
    logic                  update_pending;

    modport master (
        output load, digits_in, blank_in,
        input  dig_sel, dig_en, seg, frame_done, update_pending
    );

    modport slave (
        input  load, digits_in, blank_in,
        output dig_sel, dig_en, seg, frame_done, update_pending
    );

endinterface

// File: rtl/hex_to_7seg.sv
// Purely combinational hex nibble to 7-segment pattern decoder.
// i_hex   : 4-bit value 0..F
// o_seg_c : active-high segments {g,f,e,d,c,b,a}
module hex_to_7seg
    import disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_hex,
    output logic [SEG_W-1:0]   o_seg_c
);

    always_comb begin
        o_seg_c = SEG_0;
        case (i_hex)
            4'h0: o_seg_c = SEG_0;
            4'h1: o_seg_c = SEG_1;
            4'h2: o_seg_c = SEG_2;
            4'h3: o_seg_c = SEG_3;
            4'h4: o_seg_c = SEG_4;
            4'h5: o_seg_c = SEG_5;
            4'h6: o_seg_c = SEG_6;
            4'h7: o_seg_c = SEG_7;
            4'h8: o_seg_c = SEG_8;
            4'h9: o_seg_c = SEG_9;
            4'hA: o_seg_c = SEG_A;
            4'hB: o_seg_c = SEG_B;
            4'hC: o_seg_c = SEG_C;
            4'hD: o_seg_c = SEG_D;
            4'hE: o_seg_c = SEG_E;
            4'hF: o_seg_c = SEG_F;
            default: o_seg_c = SEG_0;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-synchronous data update.
// clk, rst_n : system clock, async active-low reset
// bus (slave): load/digits_in/blank_in in; dig_sel/dig_en/seg/frame_done/update_pending out
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                clk,
    input  logic                rst_n,
    display_scan_ctrl_if.slave  bus
);

    localparam int unsigned MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int unsigned PH_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [PH_W-1:0]  SHOW_LAST  = PH_W'(SHOW_CYCLES - 1);
    localparam logic [PH_W-1:0]  BLANK_LAST = PH_W'(BLANK_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_SLOT  = SEL_W'(NUM_DIGITS - 1);

    state_e                r_state, w_state_nxt;
    logic [SEL_W-1:0]      r_slot, w_slot_nxt;
    logic [PH_W-1:0]       r_phase, w_phase_nxt;
    logic                  r_frame_done, w_frame_done_nxt;
    disp_data_t            r_active, w_active_nxt;
    disp_data_t            r_pending, w_pending_nxt;
    logic                  r_pend_vld, w_pend_vld_nxt;
    logic [SEL_W-1:0]      r_dig_sel;
    logic [NUM_DIGITS-1:0] r_dig_en, w_dig_en_nxt;
    logic [SEG_W-1:0]      r_seg, w_seg_nxt;
    disp_data_t            w_load_data;
    logic [DIGIT_W-1:0]    w_nibble;
    logic [SEG_W-1:0]      w_seg_dec;

    assign w_load_data = {bus.digits_in, bus.blank_in};

    // Scan FSM next state: BLANK -> SHOW on same slot, SHOW -> BLANK on next slot.
    always_comb begin
        w_state_nxt      = r_state;
        w_slot_nxt       = r_slot;
        w_phase_nxt      = r_phase + PH_W'(1);
        case (r_state)
            ST_BLANK: begin
                if (r_phase == BLANK_LAST) begin
                    w_state_nxt = ST_SHOW;
                    w_phase_nxt = '0;
                end
            end
            ST_SHOW: begin
                if (r_phase == SHOW_LAST) begin
                    w_state_nxt = ST_BLANK;
                    w_slot_nxt  = r_slot + SEL_W'(1);
                    w_phase_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_phase_nxt = '0;
            end
        endcase
        // Registered pulse covers the final SHOW cycle of the last digit.
        w_frame_done_nxt = (w_state_nxt == ST_SHOW) && (w_slot_nxt == LAST_SLOT)
                        && (w_phase_nxt == SHOW_LAST);
    end

    // Data capture: active only changes at the edge closing the frame_done cycle.
    always_comb begin
        w_active_nxt   = r_active;
        w_pending_nxt  = r_pending;
        w_pend_vld_nxt = r_pend_vld;
        if (r_frame_done) begin
            if (bus.load) begin
                w_active_nxt = w_load_data;
            end else if (r_pend_vld) begin
                w_active_nxt = r_pending;
            end
            w_pend_vld_nxt = 1'b0;
        end else if (bus.load) begin
            w_pending_nxt  = w_load_data;
            w_pend_vld_nxt = 1'b1;
        end
    end

    // Outputs are derived from next-cycle state so the registers line up with the FSM.
    assign w_nibble = w_active_nxt.digits[w_slot_nxt];

    hex_to_7seg u_hex (
        .i_hex   (w_nibble),
        .o_seg_c (w_seg_dec)
    );

    always_comb begin
        w_dig_en_nxt = '0;
        w_seg_nxt    = '0;
        if ((w_state_nxt == ST_SHOW) && !w_active_nxt.blank[w_slot_nxt]) begin
            w_dig_en_nxt = NUM_DIGITS'(1) << w_slot_nxt;
            w_seg_nxt    = w_seg_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BLANK;
            r_slot       <= '0;
            r_phase      <= '0;
            r_frame_done <= 1'b0;
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_vld   <= 1'b0;
            r_dig_sel    <= '0;
            r_dig_en     <= '0;
            r_seg        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_slot       <= w_slot_nxt;
            r_phase      <= w_phase_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_active     <= w_active_nxt;
            r_pending    <= w_pending_nxt;
            r_pend_vld   <= w_pend_vld_nxt;
            r_dig_sel    <= w_slot_nxt;
            r_dig_en     <= w_dig_en_nxt;
            r_seg        <= w_seg_nxt;
        end
    end

    assign bus.dig_sel        = r_dig_sel;
    assign bus.dig_en         = r_dig_en;
    assign bus.seg            = r_seg;
    assign bus.frame_done     = r_frame_done;
    assign bus.update_pending = r_pend_vld;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with SHOW_CYCLES=4, BLANK_CYCLES=1.
// Reference model tracks position in the 20-cycle frame arithmetically.
module tb_display_scan_ctrl;
    localparam int SHOW  = 4;
    localparam int BLNK  = 1;
    localparam int SLOTL = SHOW + BLNK;
    localparam int FRAME = 4 * SLOTL;

    logic clk;
    logic rst_n;
    display_scan_ctrl_if bus();

    display_scan_ctrl #(.SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int fd_seen  = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: cycles since reset release, displayed and waiting data.
    int          k;
    logic [15:0] m_act_d, m_pend_d;
    logic [3:0]  m_act_b, m_pend_b;
    bit          m_pvld;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t k=%0d)", tag, got, exp, $time, k);
        end
    endtask

    task automatic model_reset();
        k = 0; m_act_d = '0; m_pend_d = '0; m_act_b = '0; m_pend_b = '0; m_pvld = 0;
    endtask

    task automatic check_outputs();
        int p, slot;
        bit show;
        logic [3:0] e_en;
        logic [6:0] e_seg;
        p    = k % FRAME;
        slot = p / SLOTL;
        show = (p % SLOTL) != 0;
        e_en  = '0;
        e_seg = '0;
        if (show && !m_act_b[slot]) begin
            e_en  = 4'(1 << slot);
            e_seg = hex_tab[m_act_d[slot*4 +: 4]];
        end
        check("dig_sel", 32'(bus.dig_sel), 32'(slot));
        check("dig_en", 32'(bus.dig_en), 32'(e_en));
        check("seg", 32'(bus.seg), 32'(e_seg));
        check("frame_done", 32'(bus.frame_done), 32'(p == FRAME - 1));
        check("update_pending", 32'(bus.update_pending), 32'(m_pvld));
    endtask

    task automatic tick();
        bit          ld;
        logic [15:0] d;
        logic [3:0]  b;
        ld = bus.load; d = bus.digits_in; b = bus.blank_in;
        @(posedge clk); #1;
        if ((k % FRAME) == FRAME - 1) begin
            if (ld) begin m_act_d = d; m_act_b = b; end
            else if (m_pvld) begin m_act_d = m_pend_d; m_act_b = m_pend_b; end
            m_pvld = 0;
        end else if (ld) begin
            m_pend_d = d; m_pend_b = b; m_pvld = 1;
        end
        k++;
        if (bus.frame_done) fd_seen++;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the model frame position equals p (at most one frame).
    task automatic run_to(input int p);
        for (int i = 0; i < FRAME && (k % FRAME) != p; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] b);
        bus.load = 1'b1; bus.digits_in = d; bus.blank_in = b;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dig_sel"}, 32'(bus.dig_sel), 32'd0);
        check({tag, "_dig_en"}, 32'(bus.dig_en), 32'd0);
        check({tag, "_seg"}, 32'(bus.seg), 32'd0);
        check({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        check({tag, "_upd"}, 32'(bus.update_pending), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.load = 1'b0; bus.digits_in = '0; bus.blank_in = '0;
        model_reset();
        #3;
        check_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: "0000", frame_done every 20 cycles.
        fd_seen = 0;
        run(3 * FRAME);
        check("fd_count", 32'(fd_seen), 32'd3);

        // Mid-frame load held until frame boundary.
        run_to(7);
        do_load(16'h8A10, 4'b0000);
        check("pend_after_load", 32'(bus.update_pending), 32'd1);
        run(2 * FRAME);

        // Load on the frame_done cycle goes straight to active.
        run_to(FRAME - 1);
        check("fd_before_direct", 32'(bus.frame_done), 32'd1);
        do_load(16'h1234, 4'b0000);
        check("pend_direct", 32'(bus.update_pending), 32'd0);
        run(FRAME + 3);

        // Blank mask on slots 1 and 3.
        run_to(3);
        do_load(16'h5678, 4'b1010);
        run(2 * FRAME);

        // Two loads in one frame: last wins.
        run_to(2);
        do_load(16'h1111, 4'b0000);
        run(4);
        do_load(16'h2222, 4'b0000);
        run(2 * FRAME);

        // Randomized loads.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                do_load(16'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
            else
                tick();
        end

        // Async reset mid-SHOW with a load pending.
        run_to(12);
        do_load(16'hBEEF, 4'b0000);
        check("pend_before_rst", 32'(bus.update_pending), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk); #1;
        check_zero("hold_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
